// File: rtl/iter_shift_unit_if.sv
// rtl/iter_shift_unit_if.sv - request/result handshake bundle for iter_shift_unit
interface iter_shift_unit_if #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_mode;
  logic [SHW-1:0]   in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_zero;
  logic             out_err;

  modport master (
    output in_valid, in_data, in_mode, in_amt, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero, out_err
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_amt, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero, out_err
  );
endinterface

// File: rtl/iter_shift_unit.sv
// rtl/iter_shift_unit.sv - iterative multi-mode shifter, up to STEP bit positions per clock
module iter_shift_unit #(
  parameter  int WIDTH = 8,
  parameter  int STEP  = 1,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  iter_shift_unit_if.slave bus,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [2:0] MODE_LSL = 3'd0;
  localparam logic [2:0] MODE_LSR = 3'd1;
  localparam logic [2:0] MODE_ASR = 3'd2;
  localparam logic [2:0] MODE_ROL = 3'd3;
  localparam logic [2:0] MODE_ROR = 3'd4;

  localparam logic [SHW:0] STEP_K  = (SHW+1)'(STEP);
  localparam logic [SHW:0] WIDTH_K = (SHW+1)'(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic [SHW-1:0]   rem_q;
  logic [2:0]       mode_q;
  logic             carry_q;
  logic             err_q;
  logic             ready_q;
  logic             valid_q;

  logic [SHW:0]     rem_ext;
  logic [SHW:0]     k;
  logic             last_step;
  logic [WIDTH:0]   wide_l;
  logic [WIDTH:0]   wide_r;
  logic [WIDTH:0]   wide_a;
  logic [WIDTH-1:0] step_data;
  logic             step_carry;

  assign rem_ext   = {1'b0, rem_q};
  assign k         = (rem_ext < STEP_K) ? rem_ext : STEP_K;
  assign last_step = (rem_ext == k);

  // One guard bit beyond the shifted edge catches the last bit shifted out.
  assign wide_l = {1'b0, data_q} << k;
  assign wide_r = {data_q, 1'b0} >> k;
  assign wide_a = $signed({data_q, 1'b0}) >>> k;

  always_comb begin
    step_data  = data_q;
    step_carry = carry_q;
    case (mode_q)
      MODE_LSL: {step_carry, step_data} = wide_l;
      MODE_LSR: begin
        step_data  = wide_r[WIDTH:1];
        step_carry = wide_r[0];
      end
      MODE_ASR: begin
        step_data  = wide_a[WIDTH:1];
        step_carry = wide_a[0];
      end
      MODE_ROL: begin
        step_data  = (data_q << k) | (data_q >> (WIDTH_K - k));
        step_carry = step_data[0];
      end
      MODE_ROR: begin
        step_data  = (data_q >> k) | (data_q << (WIDTH_K - k));
        step_carry = step_data[WIDTH-1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      mode_q  <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            data_q  <= bus.in_data;
            mode_q  <= bus.in_mode;
            rem_q   <= bus.in_amt;
            carry_q <= 1'b0;
            err_q   <= (bus.in_mode > MODE_ROR);
            ready_q <= 1'b0;
            // Zero-amount and illegal requests pass data straight through.
            if (bus.in_amt == '0 || bus.in_mode > MODE_ROR) begin
              state   <= DONE;
              valid_q <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data_q  <= step_data;
          carry_q <= step_carry;
          rem_q   <= rem_q - k[SHW-1:0];
          if (last_step) begin
            state   <= DONE;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_carry = carry_q;
  assign bus.out_err   = err_q;
  assign bus.out_zero  = (data_q == '0);
  assign busy          = !ready_q;
endmodule

// File: tb/tb_iter_shift_unit.sv
// tb/tb_iter_shift_unit.sv - random and directed checks of iter_shift_unit at STEP=1 and STEP=3
module tb_iter_shift_unit;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_data;
  logic [2:0] in_mode;
  logic [2:0] in_amt;
  bit         rand_bp = 1'b0;

  logic       in_ready_w  [2];
  logic       out_valid_w [2];
  logic [7:0] out_data_w  [2];
  logic       out_carry_w [2];
  logic       out_zero_w  [2];
  logic       out_err_w   [2];
  logic       busy_w      [2];

  int checks = 0;
  int errors = 0;

  iter_shift_unit_if #(.WIDTH(W)) bus [2] ();

  iter_shift_unit #(.WIDTH(W), .STEP(1)) u_step1 (
    .clk(clk), .rst_n(rst_n), .bus(bus[0]), .busy(busy_w[0])
  );
  iter_shift_unit #(.WIDTH(W), .STEP(3)) u_step3 (
    .clk(clk), .rst_n(rst_n), .bus(bus[1]), .busy(busy_w[1])
  );

  for (genvar g = 0; g < 2; g++) begin : g_wire
    assign bus[g].in_valid  = in_valid;
    assign bus[g].in_data   = in_data;
    assign bus[g].in_mode   = in_mode;
    assign bus[g].in_amt    = in_amt;
    assign bus[g].out_ready = out_ready;
    assign in_ready_w[g]    = bus[g].in_ready;
    assign out_valid_w[g]   = bus[g].out_valid;
    assign out_data_w[g]    = bus[g].out_data;
    assign out_carry_w[g]   = bus[g].out_carry;
    assign out_zero_w[g]    = bus[g].out_zero;
    assign out_err_w[g]     = bus[g].out_err;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-amount reference: returns {err, carry, data}.
  function automatic logic [9:0] ref_shift(input logic [7:0] d, input logic [2:0] m, input int amt);
    logic [7:0] r;
    logic       c;
    logic       e;
    r = d;
    c = 1'b0;
    e = 1'b0;
    case (m)
      3'd0: begin r = d << amt; c = (amt > 0) ? d[8-amt] : 1'b0; end
      3'd1: begin r = d >> amt; c = (amt > 0) ? d[amt-1] : 1'b0; end
      3'd2: begin r = $signed(d) >>> amt; c = (amt > 0) ? d[amt-1] : 1'b0; end
      3'd3: begin r = (amt > 0) ? ((d << amt) | (d >> (8-amt))) : d; c = (amt > 0) ? r[0] : 1'b0; end
      3'd4: begin r = (amt > 0) ? ((d >> amt) | (d << (8-amt))) : d; c = (amt > 0) ? r[7] : 1'b0; end
      default: e = 1'b1;
    endcase
    return {e, c, r};
  endfunction

  function automatic int lat(input logic [2:0] m, input int amt, input int step);
    return (m > 3'd4 || amt == 0) ? 0 : (amt + step - 1) / step;
  endfunction

  function automatic int step_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  // Model: 0 = idle, 1 = computing for cnt cycles, 2 = presenting a result.
  int         ph        [2] = '{0, 0};
  int         cnt       [2] = '{0, 0};
  logic [7:0] exp_d     [2] = '{8'h00, 8'h00};
  logic       exp_c     [2] = '{1'b0, 1'b0};
  logic       exp_e     [2] = '{1'b0, 1'b0};
  bit         after_rst [2] = '{1'b1, 1'b1};

  always @(posedge clk or negedge rst_n) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        ph[g] <= 0; cnt[g] <= 0; exp_d[g] <= 8'h00; exp_c[g] <= 1'b0; exp_e[g] <= 1'b0;
        after_rst[g] <= 1'b1;
      end else begin
        case (ph[g])
          0: if (in_valid) begin
            logic [9:0] r;
            int         l;
            r = ref_shift(in_data, in_mode, int'(in_amt));
            l = lat(in_mode, int'(in_amt), step_of(g));
            {exp_e[g], exp_c[g], exp_d[g]} <= r;
            after_rst[g] <= 1'b0;
            ph[g]  <= (l == 0) ? 2 : 1;
            cnt[g] <= l;
          end
          1: begin
            if (cnt[g] == 1) ph[g] <= 2;
            cnt[g] <= cnt[g] - 1;
          end
          default: if (out_ready) ph[g] <= 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("in_ready[%0d]", g), in_ready_w[g], ph[g] == 0);
      chk($sformatf("busy[%0d]", g), busy_w[g], ph[g] != 0);
      chk($sformatf("out_valid[%0d]", g), out_valid_w[g], ph[g] == 2);
      if (ph[g] == 2 || after_rst[g]) begin
        chk($sformatf("out_data[%0d]", g), out_data_w[g], exp_d[g]);
        chk($sformatf("out_carry[%0d]", g), out_carry_w[g], exp_c[g]);
        chk($sformatf("out_err[%0d]", g), out_err_w[g], exp_e[g]);
        chk($sformatf("out_zero[%0d]", g), out_zero_w[g], exp_d[g] == 8'h00);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_bp) out_ready = ($urandom_range(3) != 0);
    end
  end

  task automatic wait_idle();
    int guard = 0;
    while (!(ph[0] == 0 && ph[1] == 0) && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("wait_idle_bound", guard < 100, 1);
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] m, input logic [2:0] a);
    wait_idle();
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    in_amt   = a;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = 8'h00; in_mode = 3'd0; in_amt = 3'd0;

    chk("ref_lsl_81_1", ref_shift(8'h81, 3'd0, 1), {1'b0, 1'b1, 8'h02});
    chk("ref_asr_90_3", ref_shift(8'h90, 3'd2, 3), {1'b0, 1'b0, 8'hF2});
    chk("ref_ror_01_1", ref_shift(8'h01, 3'd4, 1), {1'b0, 1'b1, 8'h80});
    chk("ref_rol_96_4", ref_shift(8'h96, 3'd3, 4), {1'b0, 1'b1, 8'h69});
    chk("ref_lsr_ff_7", ref_shift(8'hFF, 3'd1, 7), {1'b0, 1'b1, 8'h01});
    chk("ref_lsl_80_1", ref_shift(8'h80, 3'd0, 1), {1'b0, 1'b1, 8'h00});
    chk("ref_ill_a5_2", ref_shift(8'hA5, 3'd6, 2), {1'b1, 1'b0, 8'hA5});
    chk("lat_rol4_s3", lat(3'd3, 4, 3), 2);
    chk("lat_lsr7_s3", lat(3'd1, 7, 3), 3);
    chk("lat_asr3_s1", lat(3'd2, 3, 1), 3);
    chk("lat_lsl1_s1", lat(3'd0, 1, 1), 1);
    chk("lat_ill_s1", lat(3'd6, 2, 1), 0);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    out_ready = 1'b1;
    send(8'h81, 3'd0, 3'd1);
    send(8'h90, 3'd2, 3'd3);
    send(8'h01, 3'd4, 3'd1);
    send(8'h96, 3'd3, 3'd4);
    send(8'hFF, 3'd1, 3'd7);
    send(8'h80, 3'd0, 3'd1);
    send(8'hA5, 3'd6, 3'd2);
    send(8'h3C, 3'd0, 3'd2);
    send(8'h5A, 3'd3, 3'd0);

    // Backpressure: hold results, poke in_valid while busy.
    wait_idle();
    out_ready = 1'b0;
    send(8'hC3, 3'd2, 3'd5);
    guard = 0;
    while (!(ph[0] == 2 && ph[1] == 2) && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    chk("bp_reach_done", guard < 50, 1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'hFF; in_mode = 3'd0; in_amt = 3'd7;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a STEP=1 shift.
    send(8'hF0, 3'd1, 3'd7);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", out_valid_w[0], 0);
    chk("rst_mid_data", out_data_w[0], 8'h00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(8'($urandom), 3'($urandom_range(7)), 3'($urandom_range(7)));
    end
    wait_idle();
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
